// File: rtl/fft_frame_sequencer_if.sv
// Control/handshake bundle of the FFT frame sequencer: load, butterfly issue,
// write-back and unload address streams. FFT_SEQ_INVERSE_EN adds inverse/tw_conj.
interface fft_frame_sequencer_if #(
  parameter int unsigned LOG2_N = 5
);
  localparam int unsigned AW = LOG2_N;
  localparam int unsigned TW = LOG2_N - 1;

  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic          ld_wr_en;
  logic [AW-1:0] ld_wr_addr;
  logic          bf_rd_en;
  logic [AW-1:0] bf_addr_a;
  logic [AW-1:0] bf_addr_b;
  logic [TW-1:0] tw_idx;
  logic          wb_en;
  logic [AW-1:0] wb_addr_a;
  logic [AW-1:0] wb_addr_b;
  logic [2:0]    stage;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic          out_last;
`ifdef FFT_SEQ_INVERSE_EN
  logic          inverse;
  logic          tw_conj;

  modport master (
    input  start, in_valid, out_ready, inverse,
    output busy, done, in_ready, ld_wr_en, ld_wr_addr,
           bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
           wb_en, wb_addr_a, wb_addr_b, stage,
           out_valid, out_addr, out_last, tw_conj
  );

  modport slave (
    output start, in_valid, out_ready, inverse,
    input  busy, done, in_ready, ld_wr_en, ld_wr_addr,
           bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
           wb_en, wb_addr_a, wb_addr_b, stage,
           out_valid, out_addr, out_last, tw_conj
  );
`else
  modport master (
    input  start, in_valid, out_ready,
    output busy, done, in_ready, ld_wr_en, ld_wr_addr,
           bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
           wb_en, wb_addr_a, wb_addr_b, stage,
           out_valid, out_addr, out_last
  );

  modport slave (
    output start, in_valid, out_ready,
    input  busy, done, in_ready, ld_wr_en, ld_wr_addr,
           bf_rd_en, bf_addr_a, bf_addr_b, tw_idx,
           wb_en, wb_addr_a, wb_addr_b, stage,
           out_valid, out_addr, out_last
  );
`endif

endinterface

// File: rtl/fft_frame_sequencer.sv
// Sequences one radix-2 DIT FFT frame (load, compute/drain per stage, unload) as
// addresses and strobes only. Optional inverse twiddle mode: FFT_SEQ_INVERSE_EN.
module fft_frame_sequencer #(
  parameter int unsigned NO_IN_OUT  = 32,
  parameter int unsigned LOG2_N     = 5,
  parameter int unsigned BF_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_frame_sequencer_if.master bus
);

  localparam int unsigned AW     = LOG2_N;
  localparam int unsigned KW     = LOG2_N - 1;
  localparam int unsigned HALF_N = NO_IN_OUT / 2;
  localparam int unsigned DW     = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_UNLOAD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [2:0]    stg_q, stg_d;
  logic [DW-1:0] dr_cnt_q, dr_cnt_d;
  logic [AW-1:0] un_cnt_q, un_cnt_d;
  logic          inv_q, inv_d;
  logic          done_d;

  logic          busy_q, done_q, in_ready_q;
  logic          bf_rd_en_q;
  logic [AW-1:0] bf_addr_a_q, bf_addr_b_q;
  logic [KW-1:0] tw_idx_q;
  logic [2:0]    stage_q;
  logic          out_valid_q, out_last_q;
  logic [AW-1:0] out_addr_q;
  logic          tw_conj_q;

  logic [BF_LATENCY-1:0] wb_en_pipe;
  logic [AW-1:0]         wb_a_pipe [BF_LATENCY];
  logic [AW-1:0]         wb_b_pipe [BF_LATENCY];

  logic          ld_hs, un_hs;
  logic          cd_d;
  logic [AW-1:0] kx, half, pos, addr_a_d, addr_b_d;
  logic [KW-1:0] raw_tw, tw_d;
  logic [AW-1:0] ld_rev;

  assign ld_hs = bus.in_valid & in_ready_q;
  assign un_hs = out_valid_q & bus.out_ready;

  // Next-state and counter update
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_d      = k_q;
    stg_d    = stg_q;
    dr_cnt_d = dr_cnt_q;
    un_cnt_d = un_cnt_q;
    inv_d    = inv_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
`ifdef FFT_SEQ_INVERSE_EN
          inv_d    = bus.inverse;
`else
          inv_d    = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (ld_hs) begin
          if (ld_cnt_q == AW'(NO_IN_OUT - 1)) begin
            state_d = S_COMPUTE;
            stg_d   = '0;
            k_d     = '0;
          end else begin
            ld_cnt_d = ld_cnt_q + AW'(1);
          end
        end
      end
      S_COMPUTE: begin
        if (k_q == KW'(HALF_N - 1)) begin
          state_d  = S_DRAIN;
          dr_cnt_d = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_DRAIN: begin
        if (dr_cnt_q == DW'(BF_LATENCY - 1)) begin
          if (stg_q == 3'(LOG2_N - 1)) begin
            state_d  = S_UNLOAD;
            un_cnt_d = '0;
          end else begin
            state_d = S_COMPUTE;
            stg_d   = stg_q + 3'd1;
            k_d     = '0;
          end
        end else begin
          dr_cnt_d = dr_cnt_q + DW'(1);
        end
      end
      S_UNLOAD: begin
        if (un_hs) begin
          if (un_cnt_q == AW'(NO_IN_OUT - 1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            un_cnt_d = un_cnt_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Butterfly operand/twiddle addresses for the upcoming cycle
  always_comb begin
    cd_d     = (state_d == S_COMPUTE) || (state_d == S_DRAIN);
    kx       = AW'(k_d);
    half     = AW'(1) << stg_d;
    pos      = kx & (half - AW'(1));
    addr_a_d = ((kx >> stg_d) << (stg_d + 3'd1)) + pos;
    addr_b_d = addr_a_d + half;
    raw_tw   = KW'(pos << (3'(LOG2_N - 1) - stg_d));
    tw_d     = inv_d ? (KW'(0) - raw_tw) : raw_tw;
  end

  // Load addresses are written bit-reversed so stage 0 sees DIT order
  always_comb begin
    ld_rev = '0;
    for (int i = 0; i < int'(AW); i++) begin
      ld_rev[i] = ld_cnt_q[AW-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_cnt_q    <= '0;
      k_q         <= '0;
      stg_q       <= '0;
      dr_cnt_q    <= '0;
      un_cnt_q    <= '0;
      inv_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      bf_rd_en_q  <= 1'b0;
      bf_addr_a_q <= '0;
      bf_addr_b_q <= '0;
      tw_idx_q    <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      tw_conj_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_cnt_q    <= ld_cnt_d;
      k_q         <= k_d;
      stg_q       <= stg_d;
      dr_cnt_q    <= dr_cnt_d;
      un_cnt_q    <= un_cnt_d;
      inv_q       <= inv_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      in_ready_q  <= (state_d == S_LOAD);
      bf_rd_en_q  <= (state_d == S_COMPUTE);
      bf_addr_a_q <= (state_d == S_COMPUTE) ? addr_a_d : '0;
      bf_addr_b_q <= (state_d == S_COMPUTE) ? addr_b_d : '0;
      tw_idx_q    <= (state_d == S_COMPUTE) ? tw_d : '0;
      stage_q     <= cd_d ? stg_d : '0;
      out_valid_q <= (state_d == S_UNLOAD);
      out_addr_q  <= (state_d == S_UNLOAD) ? un_cnt_d : '0;
      out_last_q  <= (state_d == S_UNLOAD) && (un_cnt_d == AW'(NO_IN_OUT - 1));
      tw_conj_q   <= inv_d & cd_d;
    end
  end

  // Write-back delay line tracking the butterfly pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_en_pipe <= '0;
      for (int i = 0; i < int'(BF_LATENCY); i++) begin
        wb_a_pipe[i] <= '0;
        wb_b_pipe[i] <= '0;
      end
    end else begin
      wb_en_pipe[0] <= bf_rd_en_q;
      wb_a_pipe[0]  <= bf_addr_a_q;
      wb_b_pipe[0]  <= bf_addr_b_q;
      for (int i = 1; i < int'(BF_LATENCY); i++) begin
        wb_en_pipe[i] <= wb_en_pipe[i-1];
        wb_a_pipe[i]  <= wb_a_pipe[i-1];
        wb_b_pipe[i]  <= wb_b_pipe[i-1];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.ld_wr_en   = ld_hs;
  assign bus.ld_wr_addr = in_ready_q ? ld_rev : '0;
  assign bus.bf_rd_en   = bf_rd_en_q;
  assign bus.bf_addr_a  = bf_addr_a_q;
  assign bus.bf_addr_b  = bf_addr_b_q;
  assign bus.tw_idx     = tw_idx_q;
  assign bus.wb_en      = wb_en_pipe[BF_LATENCY-1];
  assign bus.wb_addr_a  = wb_a_pipe[BF_LATENCY-1];
  assign bus.wb_addr_b  = wb_b_pipe[BF_LATENCY-1];
  assign bus.stage      = stage_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_addr   = out_addr_q;
  assign bus.out_last   = out_last_q;
`ifdef FFT_SEQ_INVERSE_EN
  assign bus.tw_conj    = tw_conj_q;
`else
  logic unused_conj;
  assign unused_conj = tw_conj_q;
`endif

endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Control block that sequences one 32-point radix-2 DIT FFT frame through a shared frame RAM and a single shared butterfly unit.
- Four phases per frame:
  - Load: accepts serial samples and issues bit-reversed write addresses, doing the stage-0 input reorder on the fly.
  - Compute: issues 5 stages x 16 butterfly read/twiddle/write-back commands.
  - Drain: waits for the butterfly pipeline to empty between stages.
  - Unload: streams natural-order read addresses out.
- The block holds no sample data; it produces only addresses, enables and handshakes.

Parameters:
- NO_IN_OUT, 32, FFT points per frame (power of two).
- LOG2_N, 5, log2(NO_IN_OUT); sets the address width.
- BF_LATENCY, 2, cycles from bf_rd_en to the matching write-back (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request, sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last unload handshake
- in_valid  in  1  load-phase sample valid
- in_ready  out  1  high only in LOAD
- ld_wr_en  out  1  = in_valid & in_ready
- ld_wr_addr  out  LOG2_N  bitrev(load count)
- bf_rd_en  out  1  butterfly issue strobe
- bf_addr_a  out  LOG2_N  top operand address
- bf_addr_b  out  LOG2_N  bottom operand address (= bf_addr_a + half)
- tw_idx  out  LOG2_N-1  twiddle ROM index
- wb_en  out  1  bf_rd_en delayed BF_LATENCY cycles
- wb_addr_a  out  LOG2_N  bf_addr_a delayed BF_LATENCY cycles
- wb_addr_b  out  LOG2_N  bf_addr_b delayed BF_LATENCY cycles
- stage  out  3  current stage 0..LOG2_N-1
- out_valid  out  1  unload address valid
- out_ready  in  1  downstream accept
- out_addr  out  LOG2_N  natural-order read address
- out_last  out  1  high with out_addr = NO_IN_OUT-1

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters and delay lines cleared. Asserting rst_n low mid-frame aborts immediately; the pipeline is flushed and wb_en is 0 on release.
- States: IDLE -> LOAD -> COMPUTE <-> DRAIN -> UNLOAD -> IDLE.
- IDLE:
  - start=1 -> LOAD next cycle, load count = 0.
  - in_valid is ignored here; start outside IDLE is ignored.
- LOAD:
  - Each in_valid cycle: ld_wr_en=1, ld_wr_addr = count with its LOG2_N bits reversed, count++.
  - After handshake NO_IN_OUT-1 -> COMPUTE with stage=0, k=0.
  - in_valid gaps stall the count; there is no timeout.
- COMPUTE (stage s, butterfly k = 0..NO_IN_OUT/2-1, one per cycle, no stalls):
  - half = 1<<s, pos = k & (half-1).
  - bf_addr_a = ((k>>s)<<(s+1)) + pos; bf_addr_b = bf_addr_a + half.
  - tw_idx = pos << (LOG2_N-1-s).
  - bf_rd_en=1.
  - After k = NO_IN_OUT/2-1 -> DRAIN.
- DRAIN:
  - bf_rd_en=0 for exactly BF_LATENCY cycles, a read-after-write barrier.
  - Then, if s < LOG2_N-1: s++, k=0, back to COMPUTE; else -> UNLOAD.
- Write-back path: wb_en/wb_addr_a/wb_addr_b are a BF_LATENCY-deep shift of bf_rd_en/bf_addr_a/bf_addr_b; the last wb_en of a stage occurs in the final DRAIN cycle.
- UNLOAD:
  - out_valid=1, out_addr = unload count.
  - Count advances only on out_valid & out_ready; out_ready=0 holds out_addr stable.
  - out_last=1 when the count is NO_IN_OUT-1.
  - Handshake on the last address -> IDLE, with done=1 in that next cycle.
- Cycle count: COMPUTE+DRAIN total = LOG2_N*(NO_IN_OUT/2 + BF_LATENCY) = 90 cycles at defaults.
- Counter wrap: all counters are exact width and never wrap within a frame.
- Back-to-back frames: start in the cycle done=1 is honoured, since the state is IDLE.

Optional Feature:
- Macro: FFT_SEQ_INVERSE_EN.
- Defined:
  - Adds input inverse (1 bit), sampled when start is accepted and held for the frame.
  - When held high, tw_idx output = (NO_IN_OUT/2 - raw_idx) mod (NO_IN_OUT/2), i.e. raw_idx 0 stays 0.
  - Adds output tw_conj (1 bit) = held inverse during COMPUTE/DRAIN, else 0.
- Undefined: neither port exists and tw_idx is always raw_idx.

Test Plan:
- Reset mid-COMPUTE: rst_n=0 at stage 2, k=5 -> all outputs 0 immediately; after release, state IDLE and busy=0 until start.
- Load reorder: 32 samples with in_valid always high -> ld_wr_addr sequence 0,16,8,24,4,20,...,15,31; in_ready drops after the 32nd.
- Stage 0 issue: first cycles -> (a,b,tw) = (0,1,0),(2,3,0),...,(30,31,0). Stage 2 issue: k=5 -> a=9, b=13, tw=4.
- Timing: BF_LATENCY=2 -> wb_en trails bf_rd_en by 2 cycles; 2 idle cycles between stages; 90 cycles from first COMPUTE to UNLOAD.
- Unload backpressure: out_ready toggled 1,0,0,1 -> out_addr holds at 1 for three cycles; out_last with addr 31; done pulses once; start during busy is ignored.
- FFT_SEQ_INVERSE_EN defined, inverse=1: stage 4, k=3 -> raw tw 3 becomes 13, tw_conj=1.
